// File: rtl/gnr_floyd_ctrl.sv
// gnr_floyd_ctrl: sequencer for a bank of GNR node cells with dual-trajectory
// (s0/s1) state registers. It loads an initial state, then uses Floyd cycle
// detection to find the attractor the network falls into. s0 is the tortoise
// and s1 is the hare. It reports the meeting iteration, the attractor period
// and the attractor state on a valid/ready result port.
//
// Optional feature macro: GNR_TIMEOUT_EN. When it is defined, the FIND and
// period searches stop at MAX_ITER and the result is flagged with out_timeout.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an initial state; in_ready high
// LOAD  | reset_nos strobe; nodes load init_state and set the pass flag
// FA    | tortoise and hare both step
// FB    | hare steps; the tortoise is gated off by its pass flag
// FCHK  | compare s0/s1 after one FIND iteration
// PSTEP | hare steps once around the attractor
// PCHK  | compare the hare with the captured attractor state
// DONE  | result held until out_ready
//
// The strobes are registered. Each strobe is set on the edge that enters the
// state it belongs to, so the nodes act on the edge that leaves that state.

module gnr_floyd_ctrl #(
    parameter int N_NODES  = 8,
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_NODES-1:0] in_state,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   out_period,
    output logic [CNT_W-1:0]   out_iters,
    output logic [N_NODES-1:0] out_attractor,
    output logic               out_timeout,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FA,
        S_FB,
        S_FCHK,
        S_PSTEP,
        S_PCHK,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] iters;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] iters_nxt;
    logic [CNT_W-1:0] period_nxt;

    // The limit must be reachable by the counters.
    if (MAX_ITER >= (1 << CNT_W)) begin : g_bad_max_iter
        $error("gnr_floyd_ctrl: MAX_ITER must be below 2**CNT_W");
    end

`ifdef GNR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] ITER_LIM = CNT_W'(MAX_ITER);
`else
    assign out_timeout = 1'b0;
`endif

    assign iters_nxt  = iters + CNT_W'(1);
    assign period_nxt = period + CNT_W'(1);

    // A handshake can only complete while the FSM is free to move.
    assign in_ready = (state == S_IDLE) && start;
    assign busy     = (state != S_IDLE);

    // Main sequencer. The strobes default to 0 every cycle and are raised
    // only on entry to the state that owns them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            iters         <= '0;
            period        <= '0;
            reset_nos     <= 1'b0;
            start_s0      <= 1'b0;
            start_s1      <= 1'b0;
            init_state    <= '0;
            out_valid     <= 1'b0;
            out_period    <= '0;
            out_iters     <= '0;
            out_attractor <= '0;
`ifdef GNR_TIMEOUT_EN
            out_timeout   <= 1'b0;
`endif
        end else if (!start) begin
            // Frozen. reset_nos has already had its single cycle, so
            // dropping it here keeps that cycle at exactly one.
            reset_nos <= 1'b0;
            start_s0  <= 1'b0;
            start_s1  <= 1'b0;
        end else begin
            reset_nos <= 1'b0;
            start_s0  <= 1'b0;
            start_s1  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        init_state <= in_state;
                        reset_nos  <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    iters    <= '0;
                    period   <= '0;
`ifdef GNR_TIMEOUT_EN
                    out_timeout <= 1'b0;
`endif
                    start_s0 <= 1'b1;
                    start_s1 <= 1'b1;
                    state    <= S_FA;
                end
                S_FA: begin
                    start_s0 <= 1'b1;
                    start_s1 <= 1'b1;
                    state    <= S_FB;
                end
                S_FB: begin
                    state <= S_FCHK;
                end
                S_FCHK: begin
                    iters <= iters_nxt;
                    if (s0_vec == s1_vec) begin
                        out_attractor <= s0_vec;
                        out_iters     <= iters_nxt;
                        start_s1      <= 1'b1;
                        state         <= S_PSTEP;
                    end
`ifdef GNR_TIMEOUT_EN
                    else if (iters_nxt == ITER_LIM) begin
                        out_iters   <= iters_nxt;
                        out_period  <= '0;
                        out_timeout <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= S_DONE;
                    end
`endif
                    else begin
                        start_s0 <= 1'b1;
                        start_s1 <= 1'b1;
                        state    <= S_FA;
                    end
                end
                S_PSTEP: begin
                    period <= period_nxt;
                    state  <= S_PCHK;
                end
                S_PCHK: begin
                    if (s1_vec == out_attractor) begin
                        out_period <= period;
                        out_valid  <= 1'b1;
                        state      <= S_DONE;
                    end
`ifdef GNR_TIMEOUT_EN
                    else if (period == ITER_LIM) begin
                        out_period  <= '0;
                        out_timeout <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= S_DONE;
                    end
`endif
                    else begin
                        start_s1 <= 1'b1;
                        state    <= S_PSTEP;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
